// File: rtl/cordiccart2pol_div_30s_13ns_16_if.sv
// rtl/cordiccart2pol_div_30s_13ns_16_if.sv - operand/result handshake bundle for the signed-by-unsigned divider
interface cordiccart2pol_div_30s_13ns_16_if #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 13,
    parameter int QUOT_W     = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quot;
    logic [DIVISOR_W:0]    rem;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dbz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dbz
    );
endinterface

// File: rtl/cordiccart2pol_div_30s_13ns_16.sv
// rtl/cordiccart2pol_div_30s_13ns_16.sv - radix-2 restoring signed/unsigned divider, one quotient bit per cycle
// Define CORDICCART2POL_DIV_SAT_EN to saturate quot on overflow instead of wrapping.
module cordiccart2pol_div_30s_13ns_16 #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 13,
    parameter int QUOT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    cordiccart2pol_div_30s_13ns_16_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] mag_q, mag_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic                  neg_q, neg_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    // mag_q doubles as the quotient: magnitude bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W+1:0]  diff;
    logic [QUOT_W-1:0]     quot_wrap;
    logic [QUOT_W-1:0]     quot_sat;
    logic                  fix_ovf;

    assign trial     = {prem_q[DIVISOR_W-1:0], mag_q[DIVIDEND_W-1]};
    assign diff      = {1'b0, trial} - {2'b00, div_q};
    assign quot_wrap = neg_q ? -mag_q[QUOT_W-1:0] : mag_q[QUOT_W-1:0];
    assign quot_sat  = neg_q ? Q_MIN : Q_MAX;
    assign fix_ovf   = neg_q ? (mag_q > NEG_LIM) : (mag_q > POS_LIM);

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        div_d   = div_q;
        neg_d   = neg_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        neg_d   = bus.dividend[DIVIDEND_W-1];
                        mag_d   = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
                        div_d   = bus.divisor;
                        prem_d  = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W - 1);
                        state_d = (bus.divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    mag_d  = {mag_q[DIVIDEND_W-2:0], ~diff[DIVISOR_W+1]};
                    prem_d = diff[DIVISOR_W+1] ? trial : diff[DIVISOR_W:0];
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    state_d = DONE;
                    if (div_q == '0) begin
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        rem_d  = '0;
                        quot_d = quot_sat;
                    end else begin
                        dbz_d = 1'b0;
                        ovf_d = fix_ovf;
                        rem_d = neg_q ? -prem_q : prem_q;
`ifdef CORDICCART2POL_DIV_SAT_EN
                        quot_d = fix_ovf ? quot_sat : quot_wrap;
`else
                        quot_d = quot_wrap;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            div_q   <= '0;
            neg_q   <= 1'b0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_cordiccart2pol_div_30s_13ns_16.sv
// tb/tb_cordiccart2pol_div_30s_13ns_16.sv - self-checking bench for the signed-by-unsigned divider
module tb_cordiccart2pol_div_30s_13ns_16;
`ifdef CORDICCART2POL_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint r;
        bit     ov;
        bit     dz;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cordiccart2pol_div_30s_13ns_16_if bus ();

    cordiccart2pol_div_30s_13ns_16 dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    function automatic void model(input longint a, input longint b, output longint q,
                                  output longint r, output bit ov, output bit dz);
        dz = (b == 0);
        if (dz) begin
            q  = (a < 0) ? -32768 : 32767;
            r  = 0;
            ov = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            ov = (q > 32767) || (q < -32768);
            if (ov && SAT) q = (q < 0) ? -32768 : 32767;
        end
    endfunction

    task automatic start_op(input logic [29:0] a, input logic [12:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 1;
        while (bus.out_valid !== 1'b1 && edges < budget) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_one(input logic [29:0] a, input logic [12:0] b, output logic [15:0] q,
                           output logic [13:0] r, output logic ov, output logic dz, output int lat);
        start_op(a, b);
        wait_valid(200, lat);
        q  = bus.quot;
        r  = bus.rem;
        ov = bus.ovf;
        dz = bus.dbz;
        pop();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #1 reset = 1'b1;
        #12;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b1, 1'b0, 16'h0, 14'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_asserted: got ir=%b ov=%b q=%h r=%h ovf=%b dbz=%b, expected ir=1 ov=0 all zero",
                     bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.ovf, bus.dbz);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_released: got in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_divide();
        vec_t t[$];
        logic [15:0] q; logic [13:0] r; logic ov, dz; int lat;
        t.push_back('{1000, 10, 100, 0, 1'b0, 1'b0});
        t.push_back('{-1000, 7, -142, -6, 1'b0, 1'b0});
        t.push_back('{268394497, 8191, 32767, 0, 1'b0, 1'b0});
        t.push_back('{268402687, 8191, 32767, 8190, 1'b0, 1'b0});
        t.push_back('{-32768, 1, -32768, 0, 1'b0, 1'b0});
        t.push_back('{-5, 10, 0, -5, 1'b0, 1'b0});
        t.push_back('{0, 5, 0, 0, 1'b0, 1'b0});
        foreach (t[i]) begin
            run_one(30'(t[i].a), 13'(t[i].b), q, r, ov, dz, lat);
            n_checks++;
            if ({q, r, ov, dz} !== {16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz}) begin
                n_fail++;
                $display("FAIL divide %0d/%0d: got q=%h r=%h ovf=%b dbz=%b, expected q=%h r=%h ovf=%b dbz=%b",
                         t[i].a, t[i].b, q, r, ov, dz, 16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz);
            end
            n_checks++;
            if (lat != 32) begin
                n_fail++;
                $display("FAIL divide_latency %0d/%0d: got %0d, expected 32", t[i].a, t[i].b, lat);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t t[$];
        logic [15:0] q; logic [13:0] r; logic ov, dz; int lat;
        t.push_back('{1048576, 1, SAT ? 32767 : 0, 0, 1'b1, 1'b0});
        t.push_back('{-536870912, 1, SAT ? -32768 : 0, 0, 1'b1, 1'b0});
        t.push_back('{32768, 1, SAT ? 32767 : -32768, 0, 1'b1, 1'b0});
        t.push_back('{-32769, 1, SAT ? -32768 : 32767, 0, 1'b1, 1'b0});
        foreach (t[i]) begin
            run_one(30'(t[i].a), 13'(t[i].b), q, r, ov, dz, lat);
            n_checks++;
            if ({q, r, ov, dz} !== {16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz}) begin
                n_fail++;
                $display("FAIL overflow %0d/%0d: got q=%h r=%h ovf=%b dbz=%b, expected q=%h r=%h ovf=%b dbz=%b",
                         t[i].a, t[i].b, q, r, ov, dz, 16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz);
            end
            n_checks++;
            if (lat != 32) begin
                n_fail++;
                $display("FAIL overflow_latency %0d/%0d: got %0d, expected 32", t[i].a, t[i].b, lat);
            end
        end
    endtask

    task automatic test_div_by_zero();
        vec_t t[$];
        logic [15:0] q; logic [13:0] r; logic ov, dz; int lat;
        t.push_back('{5, 0, 32767, 0, 1'b0, 1'b1});
        t.push_back('{-5, 0, -32768, 0, 1'b0, 1'b1});
        t.push_back('{0, 0, 32767, 0, 1'b0, 1'b1});
        t.push_back('{-536870912, 0, -32768, 0, 1'b0, 1'b1});
        foreach (t[i]) begin
            run_one(30'(t[i].a), 13'(t[i].b), q, r, ov, dz, lat);
            n_checks++;
            if ({q, r, ov, dz} !== {16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz}) begin
                n_fail++;
                $display("FAIL dbz %0d/0: got q=%h r=%h ovf=%b dbz=%b, expected q=%h r=%h ovf=%b dbz=%b",
                         t[i].a, q, r, ov, dz, 16'(t[i].q), 14'(t[i].r), t[i].ov, t[i].dz);
            end
            n_checks++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL dbz_latency %0d/0: got %0d, expected 2", t[i].a, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] q; logic [13:0] r; logic ov, dz; int lat;
        longint a, b, eq, er; bit eov, edz;
        logic [29:0] raw;
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 7);
            b = (mode == 0) ? 0 : (mode < 3) ? longint'($urandom_range(1, 15)) : longint'($urandom_range(1, 8191));
            if (mode[0]) begin
                a = longint'($urandom_range(0, 2000000)) - 1000000;
            end else begin
                raw = 30'($urandom);
                a = longint'($signed(raw));
            end
            model(a, b, eq, er, eov, edz);
            run_one(30'(a), 13'(b), q, r, ov, dz, lat);
            n_checks++;
            if ({q, r, ov, dz} !== {16'(eq), 14'(er), eov, edz}) begin
                n_fail++;
                $display("FAIL random %0d/%0d: got q=%h r=%h ovf=%b dbz=%b, expected q=%h r=%h ovf=%b dbz=%b",
                         a, b, q, r, ov, dz, 16'(eq), 14'(er), eov, edz);
            end
            n_checks++;
            if (lat != (edz ? 2 : 32)) begin
                n_fail++;
                $display("FAIL random_latency %0d/%0d: got %0d, expected %0d", a, b, lat, edz ? 2 : 32);
            end
        end
    endtask

    task automatic test_backpressure();
        longint eq, er; bit eov, edz; int lat;
        model(12345, 67, eq, er, eov, edz);
        start_op(30'd12345, 13'd67);
        wait_valid(200, lat);
        bus.in_valid = 1'b1; bus.dividend = 30'd999; bus.divisor = 13'd3;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b1, 1'b0, 16'(eq), 14'(er), eov, edz}) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: got ov=%b ir=%b q=%h r=%h, expected ov=1 ir=0 q=%h r=%h",
                         c, bus.out_valid, bus.in_ready, bus.quot, bus.rem, 16'(eq), 14'(er));
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        pop();
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release: got in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ce_toggle();
        int edges;
        start_op(-30'sd1000, 13'd7);
        edges = 1;
        while (bus.out_valid !== 1'b1 && edges < 200) begin
            ce = ~ce;
            @(posedge clk); #1;
            edges++;
        end
        ce = 1'b1;
        n_checks++;
        if (edges != 63) begin
            n_fail++;
            $display("FAIL ce_latency: got %0d, expected 63", edges);
        end
        n_checks++;
        if ({bus.quot, bus.rem, bus.ovf, bus.dbz} !== {16'hFF72, 14'h3FFA, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ce_result: got q=%h r=%h, expected q=ff72 r=3ffa", bus.quot, bus.rem);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        logic [15:0] q; logic [13:0] r; logic ov, dz; int lat;
        start_op(30'd1000, 13'd10);
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.ovf, bus.dbz} !== {1'b1, 1'b0, 16'h0, 14'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got ir=%b ov=%b q=%h r=%h ovf=%b dbz=%b, expected ir=1 ov=0 all zero",
                     bus.in_ready, bus.out_valid, bus.quot, bus.rem, bus.ovf, bus.dbz);
        end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_one(30'd81, 13'd9, q, r, ov, dz, lat);
        n_checks++;
        if ({q, r, ov, dz} !== {16'd9, 14'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_next: got q=%h r=%h ovf=%b dbz=%b, expected q=0009 r=0000", q, r, ov, dz);
        end
        n_checks++;
        if (lat != 32) begin
            n_fail++;
            $display("FAIL reset_mid_latency: got %0d, expected 32", lat);
        end
    endtask

    task automatic test_back_to_back();
        longint qa, ra, qb, rb; bit ova, dza, ovb, dzb;
        logic [15:0] q1; logic [13:0] r1;
        int lat; time t1, t2;
        model(-100000, 333, qa, ra, ova, dza);
        model(77777, 13, qb, rb, ovb, dzb);
        bus.out_ready = 1'b1;
        start_op(-30'sd100000, 13'd333);
        wait_valid(200, lat);
        t1 = $time;
        q1 = bus.quot; r1 = bus.rem;
        bus.dividend = 30'd77777; bus.divisor = 13'd13; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(200, lat);
        t2 = $time;
        n_checks++;
        if ({q1, r1} !== {16'(qa), 14'(ra)}) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h r=%h, expected q=%h r=%h", q1, r1, 16'(qa), 14'(ra));
        end
        n_checks++;
        if ({bus.quot, bus.rem} !== {16'(qb), 14'(rb)}) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h r=%h, expected q=%h r=%h", bus.quot, bus.rem, 16'(qb), 14'(rb));
        end
        n_checks++;
        if ((t2 - t1) != 330) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles, expected 33", (t2 - t1) / 10);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_divide();
        test_overflow();
        test_div_by_zero();
        test_backpressure();
        test_ce_toggle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
